// File: rtl/cpl_timeout_tracker.sv
// Per-tag completion-timeout tracker: ages outstanding request tags on toggles of a
// configurable time-counter bit and reports expired tags over a ready/valid channel.
module cpl_timeout_tracker #(
  parameter int ENTRY_COUNT   = 64,
  parameter int TAG_WIDTH     = 6,
  parameter int COUNTER_WIDTH = 32,
  parameter int CLK_SHIFT     = 3,
  parameter int TICKS         = 2,
  parameter int AGE_WIDTH     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           cfg_cto,
  input  logic                 cfg_disable,
  input  logic                 add_valid,
  input  logic [TAG_WIDTH-1:0] add_tag,
  input  logic                 cpl_valid,
  input  logic [TAG_WIDTH-1:0] cpl_tag,
  output logic                 to_valid,
  output logic [TAG_WIDTH-1:0] to_tag,
  input  logic                 to_ready,
  output logic [TAG_WIDTH:0]   outstanding,
  output logic                 add_dup_err,
  output logic                 cpl_late
);

  localparam int SEL_W = (COUNTER_WIDTH > 1) ? $clog2(COUNTER_WIDTH) : 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_PRESENT = 1'b1} state_e;

  // Completion Timeout encoding to nanosecond bit index; unknown codes use the 50 ms class.
  function automatic logic [5:0] cto_ns_index(input logic [3:0] code);
    case (code)
      4'b0001: return 6'd16;
      4'b0010: return 6'd22;
      4'b0101: return 6'd24;
      4'b0110: return 6'd26;
      4'b1001: return 6'd28;
      4'b1010: return 6'd30;
      4'b1101: return 6'd32;
      4'b1110: return 6'd34;
      default: return 6'd24;
    endcase
  endfunction

  function automatic logic [SEL_W-1:0] cto_bit_sel(input logic [3:0] code);
    int s;
    s = int'(cto_ns_index(code)) - CLK_SHIFT;
    if (s < 0) begin
      s = 0;
    end else if (s > COUNTER_WIDTH - 1) begin
      s = COUNTER_WIDTH - 1;
    end else begin
      s = s;
    end
    return s[SEL_W-1:0];
  endfunction

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]               cfg_cto_q;
  logic                     prev_bit_q, prev_bit_d;
  logic                     tick_q, tick_d;
  logic [SEL_W-1:0]         sel_s;

  logic [ENTRY_COUNT-1:0]   valid_q, valid_d;
  logic [ENTRY_COUNT-1:0]   expired_q, expired_d;
  logic [AGE_WIDTH-1:0]     age_q [ENTRY_COUNT];
  logic [AGE_WIDTH-1:0]     age_d [ENTRY_COUNT];

  state_e                   state_q, state_d;
  logic                     to_valid_q, to_valid_d;
  logic [TAG_WIDTH-1:0]     to_tag_q, to_tag_d;
  logic [TAG_WIDTH:0]       outstanding_q, outstanding_d;
  logic                     add_dup_err_q, add_dup_err_d;
  logic                     cpl_late_q, cpl_late_d;

  logic                     handshake_s;
  logic [ENTRY_COUNT-1:0]   pending_s;
  logic                     found_s;
  logic [TAG_WIDTH-1:0]     pick_s;

  // Time base and tick generation; a config change masks the tick for that cycle.
  always_comb begin
    cnt_d      = cnt_q + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    sel_s      = cto_bit_sel(cfg_cto);
    prev_bit_d = cnt_q[sel_s];
    tick_d     = (cnt_q[sel_s] != prev_bit_q) && !cfg_disable && (cfg_cto == cfg_cto_q);
  end

  // Per-entry update: add, then handshake clear, then retire, then ageing.
  always_comb begin
    valid_d     = valid_q;
    expired_d   = expired_q;
    age_d       = age_q;
    handshake_s = to_valid_q && to_ready;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if (add_valid && (add_tag == TAG_WIDTH'(i))) begin
        valid_d[i]   = 1'b1;
        expired_d[i] = 1'b0;
        age_d[i]     = '0;
      end else if (handshake_s && (to_tag_q == TAG_WIDTH'(i)) && expired_q[i]) begin
        // A re-armed entry has expired cleared, so the handshake leaves it alone.
        valid_d[i]   = 1'b0;
        expired_d[i] = 1'b0;
        age_d[i]     = '0;
      end else if (cpl_valid && (cpl_tag == TAG_WIDTH'(i)) &&
                   !(to_valid_q && (to_tag_q == TAG_WIDTH'(i)))) begin
        valid_d[i]   = 1'b0;
        expired_d[i] = 1'b0;
        age_d[i]     = '0;
      end else if (tick_q && valid_q[i] && !expired_q[i]) begin
        age_d[i]     = age_q[i] + AGE_WIDTH'(1);
        expired_d[i] = ((age_q[i] + AGE_WIDTH'(1)) == AGE_WIDTH'(TICKS));
      end else begin
        valid_d[i]   = valid_q[i];
      end
    end
  end

  // Lowest-index expired entry not being added or retired this cycle.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      pending_s[i] = valid_q[i] && expired_q[i] &&
                     !(add_valid && (add_tag == TAG_WIDTH'(i))) &&
                     !(cpl_valid && (cpl_tag == TAG_WIDTH'(i)));
      if (!found_s && pending_s[i]) begin
        found_s = 1'b1;
        pick_s  = TAG_WIDTH'(i);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Report channel next-state and side outputs.
  always_comb begin
    state_d       = state_q;
    to_tag_d      = to_tag_q;
    outstanding_d = '0;
    add_dup_err_d = add_valid && valid_q[add_tag];
    cpl_late_d    = cpl_valid && (state_q == S_PRESENT) && (cpl_tag == to_tag_q);
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d  = S_PRESENT;
          to_tag_d = pick_s;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_PRESENT: begin
        if (to_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PRESENT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    to_valid_d = (state_d == S_PRESENT);
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      outstanding_d = outstanding_d + (TAG_WIDTH+1)'(valid_q[i]);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      cfg_cto_q     <= 4'b0000;
      prev_bit_q    <= 1'b0;
      tick_q        <= 1'b0;
      valid_q       <= '0;
      expired_q     <= '0;
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        age_q[i] <= '0;
      end
      state_q       <= S_IDLE;
      to_valid_q    <= 1'b0;
      to_tag_q      <= '0;
      outstanding_q <= '0;
      add_dup_err_q <= 1'b0;
      cpl_late_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      cfg_cto_q     <= cfg_cto;
      prev_bit_q    <= prev_bit_d;
      tick_q        <= tick_d;
      valid_q       <= valid_d;
      expired_q     <= expired_d;
      age_q         <= age_d;
      state_q       <= state_d;
      to_valid_q    <= to_valid_d;
      to_tag_q      <= to_tag_d;
      outstanding_q <= outstanding_d;
      add_dup_err_q <= add_dup_err_d;
      cpl_late_q    <= cpl_late_d;
    end
  end

  assign to_valid    = to_valid_q;
  assign to_tag      = to_tag_q;
  assign outstanding = outstanding_q;
  assign add_dup_err = add_dup_err_q;
  assign cpl_late    = cpl_late_q;

endmodule
